addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand/result width in bits (two's complement).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has an operation pending.
REQ-006 req0_mode  input  1  requester 0 operation: 1 = subtract (a-b), 0 = add (a+b).
REQ-007 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-008 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-009 req1_valid, req1_mode, req1_a, req1_b, req1_ready: same directions, widths and meaning for requester 1.
REQ-010 res_valid  output  1  result register holds an undelivered result.
REQ-011 res_ready  input  1  consumer accepts result this cycle.
REQ-012 res_data  output  WIDTH  result modulo 2^WIDTH.
REQ-013 res_ovf  output  1  signed overflow of the delivered operation.
REQ-014 res_id  output  1  index of the requester that issued the result.
REQ-015 op_count  output  8  number of results delivered (res_valid && res_ready), wraps 255 -> 0.

Function
REQ-016 The block SHALL time-share a single combinational add/sub datapath between two requesters, registering one result at a time.
REQ-017 States: IDLE (result register empty) and HOLD (result register full); HOLD is indicated by res_valid = 1.
REQ-018 can_accept = IDLE, or HOLD with res_ready = 1 (result drains and the register reloads in the same cycle).
REQ-019 Grant: if only one reqN_valid is high, that requester is granted; if both are high, the requester other than last_id is granted; last_id resets to 1, so requester 0 wins the first contention.
REQ-020 reqN_ready = can_accept AND grantN; at most one ready SHALL be high in any cycle; ready SHALL NOT depend on res_data or any registered result value.
REQ-021 On accept (reqN_valid && reqN_ready): next edge loads res_data, res_ovf, res_id = N, last_id = N, res_valid = 1; latency one cycle, throughput one op per cycle when res_ready is held high.
REQ-022 Add: res_data = (a + b) mod 2^WIDTH; res_ovf = (a[MSB] == b[MSB]) && (res_data[MSB] != a[MSB]).
REQ-023 Subtract: res_data = (a - b) mod 2^WIDTH; res_ovf = (a[MSB] != b[MSB]) && (res_data[MSB] != a[MSB]).
REQ-024 In HOLD with res_ready = 0: res_data, res_ovf and res_id SHALL remain stable, both readies low, last_id unchanged.
REQ-025 In HOLD with res_ready = 1 and no requester valid: next edge clears res_valid (-> IDLE).
REQ-026 op_count SHALL increment on every cycle where res_valid && res_ready, independent of a simultaneous accept.
REQ-027 Requester inputs are sampled only in the accept cycle; changes on a non-granted requester SHALL have no effect.

Reset
REQ-028 rst = 1 SHALL immediately (no clock needed) force res_valid = 0, res_data = 0, res_ovf = 0, res_id = 0, op_count = 0, last_id = 1, state IDLE.
REQ-029 Reset asserted in HOLD SHALL discard the pending result without incrementing op_count; during reset both readies SHALL be 0.
REQ-030 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 Reset mid-HOLD: result pending, res_ready = 0, pulse rst -> res_valid = 0, op_count = 0 with no clock edge; next contention grants requester 0.
REQ-032 Single add: req0 add a = 0011, b = 0100, res_ready = 1 -> next cycle res_data = 0111, res_ovf = 0, res_id = 0.
REQ-033 Contention: both valid after reset; req0 subtract 0111 - 1000, req1 add 1111 + 0001 -> first result 1111 with res_ovf = 1, res_id = 0; second result 0000 with res_ovf = 0, res_id = 1; alternation continues while both stay valid.
REQ-034 Backpressure: result pending, res_ready = 0 for 3 cycles, both requests valid -> outputs stable, both readies 0; on res_ready = 1, drain and reload occur in the same cycle.
REQ-035 Exhaustive check: all 16 x 16 operand pairs in both modes through requester 1 -> res_data matches the modulo result; res_ovf = 1 exactly when the signed result is outside -8..7.
REQ-036 Counter wrap: 256 delivered results -> op_count returns to 0; the 257th delivery gives op_count = 1.

Source files
------------

// File: rtl/addsub_arbiter_if.sv
// Handshake bundle for the shared add/sub arbiter.
// Two requester channels plus one result channel.
interface addsub_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_mode;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic             req1_mode;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             res_id;

    modport master (
        output req0_valid, req0_mode, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_mode, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_data, res_ovf, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_mode, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_mode, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_data, res_ovf, res_id,
        input  res_ready
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one add/sub datapath.
// One registered result; drain and reload can share a cycle.
module addsub_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    addsub_arbiter_if.slave     bus,
    output logic [7:0]          op_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam int MSB = WIDTH - 1;

    logic [0:0]       state;
    logic             last_id;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;
    logic             id_q;

    logic             can_accept;
    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             drain;

    logic             op_mode;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic             ovf;

    // Round-robin grant: on contention, the requester not served last wins.
    always_comb begin
        can_accept = (state == IDLE) || bus.res_ready;
        grant0 = bus.req0_valid && (!bus.req1_valid || last_id);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_id);
        ready0 = !rst && can_accept && grant0;
        ready1 = !rst && can_accept && grant1;
        accept = ready0 || ready1;
        drain  = (state == HOLD) && bus.res_ready;
    end

    // Shared datapath, operands steered from the granted requester.
    always_comb begin
        op_mode = ready1 ? bus.req1_mode : bus.req0_mode;
        op_a    = ready1 ? bus.req1_a    : bus.req0_a;
        op_b    = ready1 ? bus.req1_b    : bus.req0_b;
        if (op_mode) begin
            result = op_a - op_b;
            ovf = (op_a[MSB] != op_b[MSB]) &&
                  (result[MSB] != op_a[MSB]);
        end else begin
            result = op_a + op_b;
            ovf = (op_a[MSB] == op_b[MSB]) &&
                  (result[MSB] != op_a[MSB]);
        end
    end

    // Result register and state: load on accept, empty on drain-only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_id <= 1'b1;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            id_q    <= 1'b0;
        end else if (accept) begin
            state   <= HOLD;
            last_id <= ready1;
            data_q  <= result;
            ovf_q   <= ovf;
            id_q    <= ready1;
        end else if (drain) begin
            state   <= IDLE;
        end
    end

    // Delivered-result counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 8'd0;
        end else if (drain) begin
            op_count <= op_count + 8'd1;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.res_valid  = (state == HOLD);
    assign bus.res_data   = data_q;
    assign bus.res_ovf    = ovf_q;
    assign bus.res_id     = id_q;
endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter.
// Each task drives one scenario and checks inline.
module tb_addsub_arbiter;
    logic       clk;
    logic       rst;
    logic [7:0] op_count;
    int         n_checks;
    int         n_fail;

    addsub_arbiter_if #(.WIDTH(4)) bus ();

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req0_mode  = 1'b0;
        bus.req0_a     = 4'd0;
        bus.req0_b     = 4'd0;
        bus.req1_valid = 1'b0;
        bus.req1_mode  = 1'b0;
        bus.req1_a     = 4'd0;
        bus.req1_b     = 4'd0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        #2;
        n_checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 4'd0 ||
            bus.res_ovf !== 1'b0 || bus.res_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h o=%b id=%b want 0 0 0 0",
                     bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id);
        end
        n_checks++;
        if (op_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", op_count);
        end
        n_checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got r0=%b r1=%b want 0 0",
                     bus.req0_ready, bus.req1_ready);
        end
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_single_add();
        do_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'b0011;
        bus.req0_b     = 4'b0100;
        bus.res_ready  = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ready: got r0=%b r1=%b want 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        bus.req0_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0111 ||
            bus.res_ovf !== 1'b0 || bus.res_id !== 1'b0) begin
            n_fail++;
            $display("FAIL add_result: got v=%b d=%b o=%b id=%b want 1 0111 0 0",
                     bus.res_valid, bus.res_data, bus.res_ovf, bus.res_id);
        end
        tick();
        n_checks++;
        if (bus.res_valid !== 1'b0 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL add_drain: got v=%b cnt=%0d want 0 1",
                     bus.res_valid, op_count);
        end
    endtask

    task automatic test_contention();
        logic [3:0] exp_d;
        logic       exp_o;
        logic       exp_id;
        do_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_mode  = 1'b1;
        bus.req0_a     = 4'b0111;
        bus.req0_b     = 4'b1000;
        bus.req1_valid = 1'b1;
        bus.req1_mode  = 1'b0;
        bus.req1_a     = 4'b1111;
        bus.req1_b     = 4'b0001;
        bus.res_ready  = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cont_first_grant: got r0=%b r1=%b want 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_id = (i % 2 == 1);
            exp_d  = exp_id ? 4'b0000 : 4'b1111;
            exp_o  = !exp_id;
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp_d ||
                bus.res_ovf !== exp_o || bus.res_id !== exp_id) begin
                n_fail++;
                $display("FAIL cont_result%0d: got v=%b d=%b o=%b id=%b want 1 %b %b %b",
                         i, bus.res_valid, bus.res_data, bus.res_ovf,
                         bus.res_id, exp_d, exp_o, exp_id);
            end
            n_checks++;
            if (bus.req0_ready !== exp_id || bus.req1_ready !== !exp_id) begin
                n_fail++;
                $display("FAIL cont_alt%0d: got r0=%b r1=%b want %b %b",
                         i, bus.req0_ready, bus.req1_ready, exp_id, !exp_id);
            end
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        do_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_mode  = 1'b1;
        bus.req0_a     = 4'b0111;
        bus.req0_b     = 4'b1000;
        bus.req1_valid = 1'b1;
        bus.req1_a     = 4'b1111;
        bus.req1_b     = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.req1_a = 4'(i + 3);
            #1;
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b1111 ||
                bus.res_ovf !== 1'b1 || bus.res_id !== 1'b0 ||
                bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b d=%b o=%b id=%b r0=%b r1=%b want 1 1111 1 0 0 0",
                         i, bus.res_valid, bus.res_data, bus.res_ovf,
                         bus.res_id, bus.req0_ready, bus.req1_ready);
            end
            tick();
        end
        bus.req1_a    = 4'b1111;
        bus.res_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got r0=%b r1=%b want 0 1",
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== 4'b0000 ||
            bus.res_id !== 1'b1 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL bp_reload: got v=%b d=%b id=%b cnt=%0d want 1 0000 1 1",
                     bus.res_valid, bus.res_data, bus.res_id, op_count);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'd1;
        bus.req0_b     = 4'd2;
        bus.res_ready  = 1'b1;
        tick();
        tick();
        bus.req0_valid = 1'b0;
        bus.res_ready  = 1'b0;
        tick();
        n_checks++;
        if (bus.res_valid !== 1'b1 || op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL mid_pre: got v=%b cnt=%0d want 1 1",
                     bus.res_valid, op_count);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b0 || op_count !== 8'd0 ||
            bus.res_data !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_async: got v=%b cnt=%0d d=%h want 0 0 0",
                     bus.res_valid, op_count, bus.res_data);
        end
        rst = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        #1;
        n_checks++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_regrant: got r0=%b r1=%b want 1 0",
                     bus.req0_ready, bus.req1_ready);
        end
        tick();
        n_checks++;
        if (bus.res_id !== 1'b0 || op_count !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_first: got id=%b cnt=%0d want 0 0",
                     bus.res_id, op_count);
        end
        idle_inputs();
    endtask

    task automatic test_exhaustive();
        int sa;
        int sb;
        int r;
        logic [3:0] exp_d;
        logic       exp_o;
        do_reset();
        idle_inputs();
        bus.req1_valid = 1'b1;
        bus.res_ready  = 1'b1;
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    bus.req1_mode = m[0];
                    bus.req1_a    = a[3:0];
                    bus.req1_b    = b[3:0];
                    bus.req0_a    = 4'(a + 5);
                    tick();
                    sa = (a > 7) ? a - 16 : a;
                    sb = (b > 7) ? b - 16 : b;
                    r  = (m == 1) ? sa - sb : sa + sb;
                    exp_d = r[3:0];
                    exp_o = (r < -8) || (r > 7);
                    n_checks++;
                    if (bus.res_valid !== 1'b1 || bus.res_data !== exp_d ||
                        bus.res_ovf !== exp_o || bus.res_id !== 1'b1) begin
                        n_fail++;
                        $display("FAIL exh m=%0d a=%0d b=%0d: got v=%b d=%b o=%b id=%b want 1 %b %b 1",
                                 m, a, b, bus.res_valid, bus.res_data,
                                 bus.res_ovf, bus.res_id, exp_d, exp_o);
                    end
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        idle_inputs();
        bus.req0_valid = 1'b1;
        bus.req0_a     = 4'd2;
        bus.req0_b     = 4'd2;
        bus.res_ready  = 1'b1;
        tick();
        n_checks++;
        if (op_count !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_start: got %0d want 0", op_count);
        end
        for (int i = 1; i <= 257; i++) begin
            tick();
            if (i == 255) begin
                n_checks++;
                if (op_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL wrap_255: got %0d want 255", op_count);
                end
            end else if (i == 256) begin
                n_checks++;
                if (op_count !== 8'd0) begin
                    n_fail++;
                    $display("FAIL wrap_256: got %0d want 0", op_count);
                end
            end else if (i == 257) begin
                n_checks++;
                if (op_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL wrap_257: got %0d want 1", op_count);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_single_add();
        test_contention();
        test_backpressure();
        test_reset_mid_hold();
        test_exhaustive();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
